// File: rtl/nvm_burst_reader.sv
// nvm_burst_reader
// Fetches a burst of consecutive NVM words starting at base_addr and shifts
// each word out as a one-bit stream with per-bit valid and last flags.
//
// Ports
//   clk        sole clock, rising edge
//   clr        asynchronous active-high reset
//   start      burst request, sampled only while idle
//   stop       abort; back to idle at the next edge from any state
//   base_addr  first word address, captured with start
//   burst_len  words minus one, captured with start
//   nvm_addr   registered NVM read address
//   nvm_data   NVM read data for nvm_addr (valid one cycle after it changes)
//   ser_out    serial data bit, 0 when ser_valid is low
//   ser_valid  ser_out carries a bit this cycle
//   ser_last   final bit of the final word of a burst
//   busy       block is not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; shift register held at zero
// FETCH | nvm_addr stable, NVM data lands in the shift register
// SHIFT | one bit per cycle out of the shift register
module nvm_burst_reader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] burst_len,
  output logic [ADDR_W-1:0] nvm_addr,
  input  logic [DATA_W-1:0] nvm_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] PRE_LAST = BCW'(DATA_W - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shf;
  logic [BCW-1:0]    bit_cnt;
  logic [ADDR_W-1:0] word_cnt;

  // Shift toward the output end, zero-filling the vacated bit.
  assign shreg_shf = LSB_FIRST ? {1'b0, shreg[DATA_W-1:1]}
                               : {shreg[DATA_W-2:0], 1'b0};

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  // Outputs are registered: each branch loads the value the outputs must
  // show in the state being entered, so nothing combinational reaches a pin.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      nvm_addr  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (stop) begin
      // Abort wins over everything; nvm_addr deliberately holds.
      state     <= IDLE;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          if (start) begin
            nvm_addr <= base_addr;
            word_cnt <= burst_len;
            state    <= FETCH;
            busy     <= 1'b1;
          end else begin
            shreg <= '0;
            busy  <= 1'b0;
          end
        end

        FETCH: begin
          shreg     <= nvm_data;
          bit_cnt   <= '0;
          state     <= SHIFT;
          ser_valid <= 1'b1;
          ser_out   <= out_bit(nvm_data);
          // A word has at least two bits, so its first bit is never the last.
          ser_last  <= 1'b0;
          busy      <= 1'b1;
        end

        SHIFT: begin
          shreg   <= shreg_shf;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            if (word_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              word_cnt <= word_cnt - 1'b1;
              nvm_addr <= nvm_addr + 1'b1;
              state    <= FETCH;
              busy     <= 1'b1;
            end
          end else begin
            ser_out   <= out_bit(shreg_shf);
            ser_valid <= 1'b1;
            ser_last  <= (bit_cnt == PRE_LAST) && (word_cnt == '0);
            busy      <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nvm_burst_reader.md
# nvm_burst_reader

Parametrised NVM read serializer. It fetches a burst of consecutive words from the NVM array, starting at a given base address. Each word is shifted out as a one-bit serial stream with per-bit valid and last-bit flags. It sits between the NVM macro's parallel read port and the serial host-side link. It generalises single-word reads with a fixed byte width to configurable word width, burst length, bit order and explicit abort.

## Interface
Parameters:
- DATA_W, 8: NVM word width in bits; must be ≥ 2.
- ADDR_W, 5: NVM address width; also the width of the burst-length field.
- LSB_FIRST, 0: bit order. 0 shifts MSB first; 1 shifts LSB first.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- clr  in  1  reset, asynchronous and active-high.
- start  in  1  burst request; sampled only in IDLE.
- stop  in  1  abort; returns to IDLE at the next edge from any state.
- base_addr  in  ADDR_W  first word address; captured with start.
- burst_len  in  ADDR_W  number of words minus 1 (0 = 1 word, all ones = 2^ADDR_W words); captured with start.
- nvm_addr  out  ADDR_W  registered address to the NVM.
- nvm_data  in  DATA_W  NVM read data; valid for nvm_addr by the end of the cycle after nvm_addr changes.
- ser_out  out  1  serial data bit; 0 whenever ser_valid=0.
- ser_valid  out  1  ser_out carries a bit this cycle.
- ser_last  out  1  high only during the final bit of the final word of a burst.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, FETCH, SHIFT.
- Registers:
  - shift register, DATA_W bits
  - bit counter, clog2(DATA_W) bits
  - word counter, ADDR_W bits
  - nvm_addr register
- Reset (clr=1, asynchronous):
  - state=IDLE.
  - nvm_addr=0, ser_out=0, ser_valid=0, ser_last=0, busy=0.
  - Shift register and both counters are 0.
- IDLE:
  - If start=1 and stop=0: nvm_addr←base_addr, word counter←burst_len, then go to FETCH.
  - Otherwise stay in IDLE and clear the shift register.
- FETCH:
  - nvm_addr is stable; at the edge, shift register←nvm_data, bit counter←0, then go to SHIFT.
  - ser_valid=0.
- SHIFT:
  - ser_valid=1; ser_out is shreg[DATA_W-1] (LSB_FIRST=0) or shreg[0] (LSB_FIRST=1).
  - Each edge shifts the register toward the output bit, zero-fills, and increments the bit counter.
  - When bit counter=DATA_W-1, this is the word's last bit. At that edge:
    - If word counter=0, go to IDLE.
    - Otherwise decrement the word counter, set nvm_addr←nvm_addr+1, and go to FETCH.
- ser_last = SHIFT, bit counter=DATA_W-1, and word counter=0.
- Address arithmetic is modulo 2^ADDR_W: base 31 at ADDR_W=5 continues 31, 0, 1, …
- stop has priority over every transition, including start and the last bit:
  - Next state is IDLE and the shift register is cleared.
  - nvm_addr holds its value.
  - No ser_last is emitted for an aborted burst.
- start while busy is ignored; no queuing.
- start=1 in the same cycle that a burst ends in SHIFT is ignored; the request must be reasserted in IDLE.

## Timing
- Start handshake: start sampled at edge E0. Cycle 1 is FETCH with nvm_addr=base_addr. The first bit is valid in cycle 2.
- Each word occupies DATA_W+1 cycles: 1 FETCH (bubble) plus DATA_W SHIFT cycles.
- A burst of N words runs N·(DATA_W+1) cycles from E0 to IDLE. busy is high for exactly that many cycles.
- nvm_addr updates on the edge that enters FETCH and is held through SHIFT.
- All outputs are derived from registered state, with no combinational path from inputs to outputs.
- Reset asserted mid-burst forces the reset values immediately, without waiting for a clock edge. After release, the block waits in IDLE for a new start.

## Test plan
- **Reset values:** Assert clr mid-SHIFT. Outputs drop to 0 asynchronously; busy=0. After release, with no start, the state stays IDLE.
- **Single word, MSB first:** DATA_W=8, base=3, len=0, nvm[3]=0xA5.
  - Cycle 1: nvm_addr=3.
  - Cycles 2–9: ser_out 1,0,1,0,0,1,0,1 with ser_valid=1.
  - ser_last only in cycle 9; busy low from cycle 10.
- **Burst with address wrap:** ADDR_W=5, base=30, len=2, nvm[30,31,0]=0x01,0xFF,0x80.
  - nvm_addr sequence 30, 31, 0, with a ser_valid bubble during each FETCH.
  - 27 busy cycles; ser_last in cycle 27 only.
- **LSB_FIRST=1:** word 0xA5 → ser_out 1,0,1,0,0,1,0,1 reversed, giving 1,0,1,0,0,1,0,1 LSB-first as 1,0,1,0,0,1,0,1 → check it equals bits a5[0..7] = 1,0,1,0,0,1,0,1.
- **Abort:** stop=1 on the 4th bit of word 2 of a 4-word burst. Next cycle: IDLE, ser_valid=0, no ser_last. Then start again with base=0, and word 0 streams correctly.
- **Ignored start and parameter sweep:**
  - Pulse start with base=9 while busy: the burst continues unaffected, and no new burst begins afterward.
  - Repeat the single-word case with DATA_W=16 and nvm=0x8001: 16 bits, first and last are 1.
